ahb_sram_ctrl: RTL and testbench
================================

// Module: ahb_sram_ctrl
// PURPOSE
//  AHB-Lite slave that initiates single-port SRAM accesses into the 64Kx32 byte-writable memory wrapper.
//  Zero-wait-state reads. Writes go straight to SRAM in the data phase, or through a 1-entry buffer
//  when a read takes the port. Read-after-write forwarding from the buffer. 2-cycle ERROR response
//  for unsupported or misaligned transfers. Sits between the AHB matrix slave port and the SRAM wrapper.
// PARAMETERS
//  AW  16  SRAM word-address width; the byte window is 2^(AW+2) bytes (256 KB by default)
// PORTS
//  CLK        in   1     clock
//  RST        in   1     synchronous active-high reset
//  HSEL       in   1     slave select
//  HADDR      in   AW+2  byte address
//  HTRANS     in   2     transfer type; bit 1 = NONSEQ/SEQ
//  HWRITE     in   1     1 = write
//  HSIZE      in   3     0 = byte, 1 = half, 2 = word; any other value is an error
//  HWDATA     in   32    write data, valid in the data phase
//  HREADY     in   1     bus ready; an address phase is sampled only when HREADY = 1
//  HREADYOUT  out  1     slave ready
//  HRESP      out  1     1 = ERROR
//  HRDATA     out  32    read data
//  SRAM_Q     in   32    SRAM read data, valid the cycle after a read strobe
//  SRAM_A     out  AW    SRAM word address
//  SRAM_D     out  32    SRAM write data
//  SRAM_CEN   out  1     chip enable, active low
//  SRAM_WEN   out  1     write enable, active low
//  SRAM_BWEN  out  4     per-byte write enable, active low; bit i controls byte [8i+7:8i]
// BEHAVIOUR
//  - Valid address phase: HSEL & HREADY & HTRANS[1].
//  - Byte lanes: byte uses lane HADDR[1:0]; half uses lanes {HADDR[1],0}+{0,1}; word uses all 4 lanes.
//  - Error: a valid phase with HSIZE > 2, a half with HADDR[0] = 1, or a word with HADDR[1:0] != 0.
//    Error FSM: IDLE -> ERR1 (HREADYOUT = 0, HRESP = 1) -> ERR2 (HREADYOUT = 1, HRESP = 1) -> IDLE.
//    No SRAM access and no buffer update for an errored transfer.
//  - Otherwise HREADYOUT = 1 and HRESP = 0 at all times.
//  - SRAM port priority each cycle, highest first. The port outputs are combinational from state and HADDR.
//    1) Read address phase: CEN = 0, WEN = 1, A = HADDR[AW+1:2].
//    2) Write data phase with no read address phase: CEN = 0, WEN = 0, A = registered write address,
//       D = HWDATA, BWEN = ~registered lanes.
//    3) Buffer valid: CEN = 0, WEN = 0, A/D/BWEN from the buffer; buf_valid <= 0.
//    4) Otherwise CEN = 1, WEN = 1, BWEN = 4'hF.
//  - Write data phase that coincides with a read address phase: load the buffer with the registered
//    address, the registered lanes and HWDATA; buf_valid <= 1.
//  - Invariant: the buffer is empty in every write data phase, because the preceding write address
//    phase frees the port for draining. The bench asserts this invariant.
//  - Read data phase: HRDATA byte i = buffer byte i when buf_valid & buf_addr == rd_addr_q & buf_be[i];
//    otherwise SRAM_Q byte i. HRDATA = 0 outside read data phases.
//  - Reset values: FSM = IDLE, buf_valid = 0, rd/wr phase flags = 0, HREADYOUT = 1, HRESP = 0,
//    HRDATA = 0, SRAM_CEN = 1, SRAM_WEN = 1, SRAM_BWEN = 4'hF.
//  - RST mid-operation discards a pending buffer without writing it and aborts any ERR sequence.
//  - IDLE/BUSY HTRANS and HSEL = 0 produce no access; a pending buffer still drains in that cycle.
// TESTING
//  1) Word write 0x10 = 0xDEADBEEF, idle, then read 0x10 -> write-data cycle shows CEN = 0, WEN = 0,
//     A = 4, BWEN = 4'h0; the read returns 0xDEADBEEF with zero wait states.
//  2) Byte write HADDR = 0x5, HWDATA = 0x0000AB00 -> A = 1, BWEN = 4'b1101; a read of 0x4 returns
//     0x0000AB00 over the prior zero.
//  3) Write 0x20 = 0x11223344, then immediately read 0x20 -> the read takes the port, the buffer loads,
//     HRDATA = 0x11223344 by forwarding, and the buffer drains at the next non-read cycle.
//  4) Word 0x20 = 0xAAAAAAAA, then half write 0x22 = 0x5555xxxx, then immediately read 0x20 ->
//     HRDATA = 0x5555AAAA (upper half forwarded, lower half from SRAM).
//  5) HSIZE = 3, or a word at 0x2 -> HREADYOUT 0 then 1 with HRESP = 1 on both cycles; CEN stays 1.
//     The following valid transfer completes normally.
//  6) Assert RST while buf_valid = 1 -> no SRAM write occurs; all outputs take their reset values next cycle.

Source files
------------

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave in front of a single-port byte-writable SRAM wrapper.
// Zero-wait reads, 1-entry write buffer with forwarding, 2-cycle ERROR.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_hsel .. i_hready    AHB-Lite address/data phase inputs
//   o_hreadyout, o_hresp  slave ready, ERROR response
//   o_hrdata              read data (0 outside read data phases)
//   i_sram_q              SRAM read data, valid the cycle after a read strobe
//   o_sram_*              SRAM address, data, active-low strobes and byte enables
module ahb_sram_ctrl #(
    parameter int AW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_hsel,
    input  logic [AW+1:0] i_haddr,
    input  logic [1:0]    i_htrans,
    input  logic          i_hwrite,
    input  logic [2:0]    i_hsize,
    input  logic [31:0]   i_hwdata,
    input  logic          i_hready,
    output logic          o_hreadyout,
    output logic          o_hresp,
    output logic [31:0]   o_hrdata,
    input  logic [31:0]   i_sram_q,
    output logic [AW-1:0] o_sram_a,
    output logic [31:0]   o_sram_d,
    output logic          o_sram_cen,
    output logic          o_sram_wen,
    output logic [3:0]    o_sram_bwen
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ERR1 = 2'd1,
        S_ERR2 = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic          r_rd_ph;
    logic [AW-1:0] r_rd_addr;
    logic          r_wr_ph;
    logic [AW-1:0] r_wr_addr;
    logic [3:0]    r_wr_be;

    logic          r_buf_valid;
    logic [AW-1:0] r_buf_addr;
    logic [3:0]    r_buf_be;
    logic [31:0]   r_buf_data;

    logic          w_valid;
    logic          w_err;
    logic          w_rd;
    logic          w_wr;
    logic [3:0]    w_be;
    logic          w_wr_go;
    logic          w_drain;
    logic          w_unused;

    // SEQ vs NONSEQ is irrelevant: every beat carries its own address.
    assign w_unused = i_htrans[0];

    // Reset gates new accesses so no SRAM cycle is issued while in reset.
    assign w_valid = ~i_rst & i_hsel & i_hready & i_htrans[1];

    always_comb begin
        w_err = 1'b0;
        w_be  = 4'hF;
        case (i_hsize)
            3'd0: w_be = 4'b0001 << i_haddr[1:0];
            3'd1: begin
                w_be  = i_haddr[1] ? 4'b1100 : 4'b0011;
                w_err = i_haddr[0];
            end
            3'd2: begin
                w_be  = 4'hF;
                w_err = (i_haddr[1:0] != 2'd0);
            end
            default: w_err = 1'b1;
        endcase
    end

    assign w_rd    = w_valid & ~w_err & ~i_hwrite;
    assign w_wr    = w_valid & ~w_err & i_hwrite;
    assign w_wr_go = ~i_rst & r_wr_ph;
    // The buffer only gets the port when nobody else wants it.
    assign w_drain = ~i_rst & r_buf_valid & ~w_rd & ~r_wr_ph;

    // Error FSM: state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Error FSM: next state; a new bad transfer may start in ERR2
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_valid && w_err) w_state_nxt = S_ERR1;
            S_ERR1:  w_state_nxt = S_ERR2;
            S_ERR2:  w_state_nxt = (w_valid && w_err) ? S_ERR1 : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Error FSM: outputs
    always_comb begin
        o_hreadyout = 1'b1;
        o_hresp     = 1'b0;
        case (r_state)
            S_ERR1: begin
                o_hreadyout = 1'b0;
                o_hresp     = 1'b1;
            end
            S_ERR2: o_hresp = 1'b1;
            default: ;
        endcase
    end

    // Data-phase bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ph   <= 1'b0;
            r_wr_ph   <= 1'b0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_be   <= '0;
        end else if (i_hready) begin
            r_rd_ph <= w_rd;
            r_wr_ph <= w_wr;
            if (w_rd) r_rd_addr <= i_haddr[AW+1:2];
            if (w_wr) begin
                r_wr_addr <= i_haddr[AW+1:2];
                r_wr_be   <= w_be;
            end
        end
    end

    // Write buffer: parks a write whose data phase collides with a read
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_buf_valid <= 1'b0;
            r_buf_addr  <= '0;
            r_buf_be    <= '0;
            r_buf_data  <= '0;
        end else if (r_wr_ph && w_rd) begin
            r_buf_valid <= 1'b1;
            r_buf_addr  <= r_wr_addr;
            r_buf_be    <= r_wr_be;
            r_buf_data  <= i_hwdata;
        end else if (w_drain) begin
            r_buf_valid <= 1'b0;
        end
    end

    // SRAM port arbitration: read > direct write > buffer drain
    always_comb begin
        o_sram_cen  = 1'b1;
        o_sram_wen  = 1'b1;
        o_sram_bwen = 4'hF;
        o_sram_a    = i_haddr[AW+1:2];
        o_sram_d    = '0;
        if (w_rd) begin
            o_sram_cen = 1'b0;
        end else if (w_wr_go) begin
            o_sram_cen  = 1'b0;
            o_sram_wen  = 1'b0;
            o_sram_a    = r_wr_addr;
            o_sram_d    = i_hwdata;
            o_sram_bwen = ~r_wr_be;
        end else if (w_drain) begin
            o_sram_cen  = 1'b0;
            o_sram_wen  = 1'b0;
            o_sram_a    = r_buf_addr;
            o_sram_d    = r_buf_data;
            o_sram_bwen = ~r_buf_be;
        end
    end

    // Read data with per-byte forwarding from the buffer
    always_comb begin
        o_hrdata = '0;
        if (r_rd_ph) begin
            for (int i = 0; i < 4; i++) begin
                if (r_buf_valid && (r_buf_addr == r_rd_addr) && r_buf_be[i]) begin
                    o_hrdata[8*i +: 8] = r_buf_data[8*i +: 8];
                end else begin
                    o_hrdata[8*i +: 8] = i_sram_q[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed self-checking bench for ahb_sram_ctrl with a behavioural SRAM.
// Inputs change 1 time unit after posedge; outputs are checked at negedge.
module tb_ahb_sram_ctrl;

    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          hsel;
    logic [AW+1:0] haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [31:0]   hwdata;
    logic          hready;
    logic          hreadyout;
    logic          hresp;
    logic [31:0]   hrdata;
    logic [31:0]   sram_q;
    logic [AW-1:0] sram_a;
    logic [31:0]   sram_d;
    logic          sram_cen;
    logic          sram_wen;
    logic [3:0]    sram_bwen;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;

    logic [31:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    // Single-slave bus: HREADY is this slave's own HREADYOUT.
    assign hready = hreadyout;

    ahb_sram_ctrl #(.AW(AW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_hsel      (hsel),
        .i_haddr     (haddr),
        .i_htrans    (htrans),
        .i_hwrite    (hwrite),
        .i_hsize     (hsize),
        .i_hwdata    (hwdata),
        .i_hready    (hready),
        .o_hreadyout (hreadyout),
        .o_hresp     (hresp),
        .o_hrdata    (hrdata),
        .i_sram_q    (sram_q),
        .o_sram_a    (sram_a),
        .o_sram_d    (sram_d),
        .o_sram_cen  (sram_cen),
        .o_sram_wen  (sram_wen),
        .o_sram_bwen (sram_bwen)
    );

    // Behavioural SRAM: active-low strobes, Q valid the cycle after a read
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_wen) begin
                wr_cnt++;
                for (int i = 0; i < 4; i++)
                    if (!sram_bwen[i]) mem[sram_a][8*i +: 8] <= sram_d[8*i +: 8];
            end else begin
                sram_q <= mem[sram_a];
            end
        end
    end

    // The buffer must be empty whenever a write data phase is in progress
    always @(negedge clk) begin
        if (!rst && dut.r_wr_ph && dut.r_buf_valid) begin
            bad++;
            $display("FAIL buf_empty_in_wr_phase got=1 exp=0 t=%0t", $time);
        end
    end

    task automatic drive(input logic s, input logic [1:0] t, input logic w,
                         input logic [2:0] z, input logic [AW+1:0] a,
                         input logic [31:0] d);
        hsel = s; htrans = t; hwrite = w; hsize = z; haddr = a; hwdata = d;
        #4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] d);
        drive(1'b0, 2'b00, 1'b0, 3'd0, '0, d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(32'h0);
        tick(); tick();
        rst = 1'b0;
        idle(32'h0);
        total++; if (hreadyout !== 1'b1) begin bad++; $display("FAIL rst_hreadyout got=%b exp=1", hreadyout); end
        total++; if (hresp !== 1'b0) begin bad++; $display("FAIL rst_hresp got=%b exp=0", hresp); end
        total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL rst_hrdata got=%h exp=0", hrdata); end
        total++; if (sram_cen !== 1'b1) begin bad++; $display("FAIL rst_cen got=%b exp=1", sram_cen); end
        total++; if (sram_wen !== 1'b1) begin bad++; $display("FAIL rst_wen got=%b exp=1", sram_wen); end
        total++; if (sram_bwen !== 4'hF) begin bad++; $display("FAIL rst_bwen got=%h exp=f", sram_bwen); end
        tick();
    endtask

    task automatic test_word();
        drive(1'b1, 2'b10, 1'b1, 3'd2, 18'h10, 32'h0);
        total++; if (sram_cen !== 1'b1) begin bad++; $display("FAIL t1_addr_cen got=%b exp=1", sram_cen); end
        tick();
        idle(32'hDEADBEEF);
        total++; if (sram_cen !== 1'b0) begin bad++; $display("FAIL t1_wr_cen got=%b exp=0", sram_cen); end
        total++; if (sram_wen !== 1'b0) begin bad++; $display("FAIL t1_wr_wen got=%b exp=0", sram_wen); end
        total++; if (sram_a !== 16'd4) begin bad++; $display("FAIL t1_wr_a got=%h exp=4", sram_a); end
        total++; if (sram_bwen !== 4'h0) begin bad++; $display("FAIL t1_wr_bwen got=%h exp=0", sram_bwen); end
        total++; if (sram_d !== 32'hDEADBEEF) begin bad++; $display("FAIL t1_wr_d got=%h exp=deadbeef", sram_d); end
        tick();
        drive(1'b1, 2'b10, 1'b0, 3'd2, 18'h10, 32'h0);
        total++; if ({sram_cen, sram_wen} !== 2'b01) begin bad++; $display("FAIL t1_rd_strobe got=%b exp=01", {sram_cen, sram_wen}); end
        total++; if (sram_a !== 16'd4) begin bad++; $display("FAIL t1_rd_a got=%h exp=4", sram_a); end
        tick();
        idle(32'h0);
        total++; if (hreadyout !== 1'b1) begin bad++; $display("FAIL t1_rd_ready got=%b exp=1", hreadyout); end
        total++; if (hrdata !== 32'hDEADBEEF) begin bad++; $display("FAIL t1_rd_data got=%h exp=deadbeef", hrdata); end
        tick();
    endtask

    task automatic test_byte();
        drive(1'b1, 2'b10, 1'b1, 3'd0, 18'h5, 32'h0);
        tick();
        idle(32'h0000AB00);
        total++; if (sram_a !== 16'd1) begin bad++; $display("FAIL t2_a got=%h exp=1", sram_a); end
        total++; if (sram_bwen !== 4'b1101) begin bad++; $display("FAIL t2_bwen got=%b exp=1101", sram_bwen); end
        total++; if (sram_wen !== 1'b0) begin bad++; $display("FAIL t2_wen got=%b exp=0", sram_wen); end
        tick();
        drive(1'b1, 2'b10, 1'b0, 3'd2, 18'h4, 32'h0);
        tick();
        idle(32'h0);
        total++; if (hrdata !== 32'h0000AB00) begin bad++; $display("FAIL t2_rd got=%h exp=0000ab00", hrdata); end
        tick();
    endtask

    task automatic test_fwd();
        drive(1'b1, 2'b10, 1'b1, 3'd2, 18'h20, 32'h0);
        tick();
        drive(1'b1, 2'b10, 1'b0, 3'd2, 18'h20, 32'h11223344);
        total++; if ({sram_cen, sram_wen} !== 2'b01) begin bad++; $display("FAIL t3_rd_wins got=%b exp=01", {sram_cen, sram_wen}); end
        total++; if (sram_a !== 16'd8) begin bad++; $display("FAIL t3_rd_a got=%h exp=8", sram_a); end
        tick();
        idle(32'h0);
        total++; if (hrdata !== 32'h11223344) begin bad++; $display("FAIL t3_fwd got=%h exp=11223344", hrdata); end
        total++; if ({sram_cen, sram_wen} !== 2'b00) begin bad++; $display("FAIL t3_drain got=%b exp=00", {sram_cen, sram_wen}); end
        total++; if (sram_d !== 32'h11223344) begin bad++; $display("FAIL t3_drain_d got=%h exp=11223344", sram_d); end
        total++; if (sram_bwen !== 4'h0) begin bad++; $display("FAIL t3_drain_bwen got=%h exp=0", sram_bwen); end
        tick();
        idle(32'h0);
        total++; if (sram_cen !== 1'b1) begin bad++; $display("FAIL t3_after_drain got=%b exp=1", sram_cen); end
        tick();
        drive(1'b1, 2'b10, 1'b0, 3'd2, 18'h20, 32'h0);
        tick();
        idle(32'h0);
        total++; if (hrdata !== 32'h11223344) begin bad++; $display("FAIL t3_sram got=%h exp=11223344", hrdata); end
        tick();
    endtask

    task automatic test_half();
        drive(1'b1, 2'b10, 1'b1, 3'd2, 18'h20, 32'h0);
        tick();
        idle(32'hAAAAAAAA);
        tick();
        drive(1'b1, 2'b10, 1'b1, 3'd1, 18'h22, 32'h0);
        tick();
        drive(1'b1, 2'b10, 1'b0, 3'd2, 18'h20, 32'h55551234);
        tick();
        idle(32'h0);
        total++; if (hrdata !== 32'h5555AAAA) begin bad++; $display("FAIL t4_fwd got=%h exp=5555aaaa", hrdata); end
        total++; if (sram_bwen !== 4'b0011) begin bad++; $display("FAIL t4_drain_bwen got=%b exp=0011", sram_bwen); end
        tick();
        idle(32'h0);
        tick();
        drive(1'b1, 2'b10, 1'b0, 3'd2, 18'h20, 32'h0);
        tick();
        idle(32'h0);
        total++; if (hrdata !== 32'h5555AAAA) begin bad++; $display("FAIL t4_sram got=%h exp=5555aaaa", hrdata); end
        tick();
    endtask

    task automatic test_err();
        int w0;
        w0 = wr_cnt;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) drive(1'b1, 2'b10, 1'b1, 3'd3, 18'h40, 32'h0);
            else        drive(1'b1, 2'b10, 1'b0, 3'd2, 18'h2, 32'h0);
            total++; if (sram_cen !== 1'b1) begin bad++; $display("FAIL t5_%0d_addr_cen got=%b exp=1", k, sram_cen); end
            tick();
            idle(32'h12345678);
            total++; if ({hreadyout, hresp} !== 2'b01) begin bad++; $display("FAIL t5_%0d_err1 got=%b exp=01", k, {hreadyout, hresp}); end
            total++; if (sram_cen !== 1'b1) begin bad++; $display("FAIL t5_%0d_err1_cen got=%b exp=1", k, sram_cen); end
            tick();
            idle(32'h0);
            total++; if ({hreadyout, hresp} !== 2'b11) begin bad++; $display("FAIL t5_%0d_err2 got=%b exp=11", k, {hreadyout, hresp}); end
            total++; if (sram_cen !== 1'b1) begin bad++; $display("FAIL t5_%0d_err2_cen got=%b exp=1", k, sram_cen); end
            tick();
            drive(1'b1, 2'b10, 1'b0, 3'd2, 18'h10, 32'h0);
            total++; if ({hreadyout, hresp} !== 2'b10) begin bad++; $display("FAIL t5_%0d_okay got=%b exp=10", k, {hreadyout, hresp}); end
            tick();
            idle(32'h0);
            total++; if (hrdata !== 32'hDEADBEEF) begin bad++; $display("FAIL t5_%0d_next got=%h exp=deadbeef", k, hrdata); end
            tick();
        end
        total++; if (wr_cnt !== w0) begin bad++; $display("FAIL t5_no_write got=%0d exp=%0d", wr_cnt, w0); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 2'b10, 1'b1, 3'd2, 18'h40, 32'h0);
        tick();
        drive(1'b1, 2'b10, 1'b1, 3'd2, 18'h44, 32'h00000001);
        total++; if (sram_a !== 16'd16) begin bad++; $display("FAIL bb_wr0_a got=%h exp=10", sram_a); end
        tick();
        drive(1'b1, 2'b10, 1'b0, 3'd2, 18'h40, 32'h00000002);
        tick();
        drive(1'b1, 2'b10, 1'b0, 3'd2, 18'h44, 32'h0);
        total++; if (hrdata !== 32'h00000001) begin bad++; $display("FAIL bb_rd0 got=%h exp=1", hrdata); end
        tick();
        idle(32'h0);
        total++; if (hrdata !== 32'h00000002) begin bad++; $display("FAIL bb_rd1_fwd got=%h exp=2", hrdata); end
        total++; if (sram_a !== 16'd17) begin bad++; $display("FAIL bb_drain_a got=%h exp=11", sram_a); end
        tick();
    endtask

    task automatic test_rst_mid();
        int w0;
        drive(1'b1, 2'b10, 1'b1, 3'd2, 18'h30, 32'h0);
        tick();
        drive(1'b1, 2'b10, 1'b0, 3'd2, 18'h34, 32'hCAFEF00D);
        tick();
        w0 = wr_cnt;
        rst = 1'b1;
        idle(32'h0);
        tick();
        rst = 1'b0;
        idle(32'h0);
        total++; if ({hreadyout, hresp} !== 2'b10) begin bad++; $display("FAIL t6_resp got=%b exp=10", {hreadyout, hresp}); end
        total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL t6_hrdata got=%h exp=0", hrdata); end
        total++; if ({sram_cen, sram_wen, sram_bwen} !== 6'b111111) begin bad++; $display("FAIL t6_sram got=%b exp=111111", {sram_cen, sram_wen, sram_bwen}); end
        tick();
        total++; if (wr_cnt !== w0) begin bad++; $display("FAIL t6_no_write got=%0d exp=%0d", wr_cnt, w0); end
        drive(1'b1, 2'b10, 1'b0, 3'd2, 18'h30, 32'h0);
        tick();
        idle(32'h0);
        total++; if (hrdata !== 32'h0) begin bad++; $display("FAIL t6_dropped got=%h exp=0", hrdata); end
        tick();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        sram_q = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_fwd();
        test_half();
        test_err();
        test_back_to_back();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
